keypad_matrix_loader: RTL and testbench
=======================================

# keypad_matrix_loader

Collects the keypad's decoded key stream into the sample matrix X and target vector y used by the regression datapath. Sits directly downstream of the keypad decoder: it turns digit, enter, clear and done keys into multi-digit unsigned elements. Each finished element is stored in row-major order into packed buses. When the matrix is complete it asserts `ready_input_matrix`. It also exposes the in-progress entry value for the OLED colour generator.

## Interface
- `ELEM_WIDTH`, 12, bits per stored element (unsigned)
- `NUM_SAMPLES`, 3, rows of X / length of y
- `NUM_FEATURES`, 2, columns of X
- `clk` input 1: single clock, all state on rising edge
- `rst_n` input 1: reset is synchronous and active-low
- `key_valid` input 1: one-cycle strobe, new key present on `key_code`
- `key_code` input 4: 0–9 digit, 4'hC clear, 4'hD done, 4'hE enter; others ignored
- `X_out` output NUM_SAMPLES*NUM_FEATURES*ELEM_WIDTH: element (i,j) at `[(i*NUM_FEATURES+j)*ELEM_WIDTH +: ELEM_WIDTH]`
- `y_out` output NUM_SAMPLES*ELEM_WIDTH: element i at `[i*ELEM_WIDTH +: ELEM_WIDTH]`
- `entry_value` output ELEM_WIDTH: accumulator for the element being typed
- `elem_count` output 4: number of elements stored so far (0..NUM_SAMPLES*(NUM_FEATURES+1))
- `ready_input_matrix` output 1: high while state is LOADED
- `error_overflow` output 1: sticky; a digit was rejected because it would overflow
- `error_incomplete` output 1: sticky; done was pressed before all elements were stored

## Operation
- TOTAL = NUM_SAMPLES*NUM_FEATURES + NUM_SAMPLES (9 at defaults).
- Elements 0..S*F-1 fill X_out in row-major order; the remaining S elements fill y_out.
- States:
  - COLLECT (reset): accepting digits and enter.
  - FULL: count == TOTAL; waiting for done.
  - LOADED: matrix handed off.
- Digit d in COLLECT:
  - Compute `acc*10 + d` in ELEM_WIDTH+4 bits.
  - If the result is ≤ 2^ELEM_WIDTH−1, store it in the accumulator.
  - Otherwise keep the accumulator unchanged and set `error_overflow`.
- Digits in FULL or LOADED are ignored.
- Enter in COLLECT:
  - Write the accumulator to slot `elem_count`, then increment `elem_count` and zero the accumulator.
  - Enter with no digits typed stores 0.
  - If the new count equals TOTAL, go to FULL.
- Enter in FULL or LOADED is ignored.
- Clear:
  - In COLLECT, zero the accumulator only.
  - In FULL or LOADED, zero X_out, y_out, accumulator, `elem_count` and both error flags, then go to COLLECT.
- Done:
  - In FULL, go to LOADED.
  - In COLLECT, set `error_incomplete` and stay in COLLECT.
  - In LOADED, ignored.
- Error flags clear only on reset or on clear from FULL/LOADED.
- `key_valid` low: no state change.
- Unlisted codes (4'hA, 4'hB, 4'hF): no effect.
- Reset values: all outputs 0, state COLLECT.

## Timing
- Every key takes effect on the clock edge where `key_valid`=1. Updated outputs are visible the next cycle.
- Consecutive-cycle strobes are each processed; no back-pressure.
- `ready_input_matrix` rises exactly 1 cycle after the done strobe in FULL. It falls 1 cycle after a clear strobe.
- `X_out` and `y_out` are registered and change only on an enter or clear edge.
- `rst_n` low on any edge, including mid-entry or in LOADED, forces reset values on that edge. Reset wins over a simultaneous `key_valid`.
- The upstream decoder must deliver one strobe per physical press. This block performs no debouncing.

## Structure
- Package `keypad_pkg`:
  - key-code localparams: KEY_CLEAR=4'hC, KEY_DONE=4'hD, KEY_ENTER=4'hE
  - state enum: COLLECT, FULL, LOADED
  - default width constants shared with the regression core
- Sub-module `digit_accumulator`:
  - holds the accumulator; performs multiply-by-10, add, overflow check and clear
  - ports: clk, rst_n, digit strobe, digit, clr, value, overflow pulse
- The top FSM owns slot writes, the counter and the error flags.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with key strobes active → all outputs 0, state COLLECT.
- Full load: keys 1,2,E, 3,E, 4,E, 5,E, 6,E, 7,E, 8,E, 9,E, 1,0,E, then D.
  - X_out elements are 12,3,4,5,6,7; y_out elements are 8,9,10.
  - `ready_input_matrix` goes to 1 one cycle after D.
- Overflow: type 4,0,9,5 → `entry_value`=4095. Then 7 → value stays 4095 and `error_overflow`=1. Then E stores 4095.
- Early done: 3 enters then D → `error_incomplete`=1, `ready_input_matrix`=0. A further enter still advances `elem_count` to 4.
- Clear paths:
  - In COLLECT, 5,C,E stores 0.
  - In LOADED, C zeroes all buses, `elem_count`=0 and `ready_input_matrix`=0 the next cycle.
- Reset mid-entry: type 7 with 4 elements stored, pulse `rst_n` low for 1 cycle → every output returns to 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key codes, loader states and default widths shared with the regression core
package keypad_pkg;
   localparam logic [3:0] KEY_CLEAR = 4'hC;
   localparam logic [3:0] KEY_DONE  = 4'hD;
   localparam logic [3:0] KEY_ENTER = 4'hE;
   localparam int ELEM_WIDTH_DEF   = 12;
   localparam int NUM_SAMPLES_DEF  = 3;
   localparam int NUM_FEATURES_DEF = 2;
   typedef enum logic [1:0] {COLLECT, FULL, LOADED} state_t;
endpackage

// File: rtl/digit_accumulator.sv
// digit_accumulator: builds a multi-digit unsigned value, rejecting digits that would overflow
module digit_accumulator #(
   parameter int W = 12
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         digit_strobe,
   input  logic [3:0]   digit,
   input  logic         clr,
   output logic [W-1:0] value,
   output logic         overflow
);
   logic [W+3:0] nxt;
   assign nxt      = ({4'd0, value} << 3) + ({4'd0, value} << 1) + {{W{1'b0}}, digit};
   assign overflow = digit_strobe & (|nxt[W+3:W]);
   // accumulator: clear wins, otherwise take value*10+digit when it still fits
   always_ff @(posedge clk) begin
      if (!rst_n || clr) value <= '0;
      else if (digit_strobe && !overflow) value <= nxt[W-1:0];
   end
endmodule

// File: rtl/keypad_matrix_loader.sv
// keypad_matrix_loader: turns decoded keys into the packed X matrix and y vector
module keypad_matrix_loader
   import keypad_pkg::*;
#(
   parameter int ELEM_WIDTH   = ELEM_WIDTH_DEF,
   parameter int NUM_SAMPLES  = NUM_SAMPLES_DEF,
   parameter int NUM_FEATURES = NUM_FEATURES_DEF
) (
   input  logic                                       clk,
   input  logic                                       rst_n,
   input  logic                                       key_valid,
   input  logic [3:0]                                 key_code,
   output logic [NUM_SAMPLES*NUM_FEATURES*ELEM_WIDTH-1:0] X_out,
   output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]          y_out,
   output logic [ELEM_WIDTH-1:0]                      entry_value,
   output logic [3:0]                                 elem_count,
   output logic                                       ready_input_matrix,
   output logic                                       error_overflow,
   output logic                                       error_incomplete
);
   localparam int XN    = NUM_SAMPLES * NUM_FEATURES;
   localparam int TOTAL = XN + NUM_SAMPLES;
   state_t                      state;
   logic [TOTAL*ELEM_WIDTH-1:0] slots;
   logic                        collect, is_digit, enter, clear, done, ovf;
   assign collect  = (state == COLLECT);
   assign is_digit = key_valid && (key_code <= 4'd9);
   assign enter    = key_valid && (key_code == KEY_ENTER);
   assign clear    = key_valid && (key_code == KEY_CLEAR);
   assign done     = key_valid && (key_code == KEY_DONE);
   assign X_out    = slots[XN*ELEM_WIDTH-1:0];
   assign y_out    = slots[TOTAL*ELEM_WIDTH-1:XN*ELEM_WIDTH];
   assign ready_input_matrix = (state == LOADED);
   digit_accumulator #(.W(ELEM_WIDTH)) u_acc (
      .clk          (clk),
      .rst_n        (rst_n),
      .digit_strobe (is_digit && collect),
      .digit        (key_code),
      .clr          (clear || (enter && collect)),
      .value        (entry_value),
      .overflow     (ovf)
   );
   // loader FSM: slot writes, element counter and sticky error flags
   always_ff @(posedge clk) begin
      if (!rst_n || (clear && !collect)) begin
         state            <= COLLECT;
         slots            <= '0;
         elem_count       <= '0;
         error_overflow   <= 1'b0;
         error_incomplete <= 1'b0;
      end else begin
         if (enter && collect) begin
            slots[elem_count*ELEM_WIDTH +: ELEM_WIDTH] <= entry_value;
            elem_count <= elem_count + 4'd1;
            if (elem_count == 4'(TOTAL - 1)) state <= FULL;
         end
         if (done && state == FULL) state <= LOADED;
         if (done && collect) error_incomplete <= 1'b1;
         if (ovf) error_overflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_keypad_matrix_loader.sv
// tb_keypad_matrix_loader: directed keypad sequences with hand-computed expectations
module tb_keypad_matrix_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic [71:0] X_out;
   logic [35:0] y_out;
   logic [11:0] entry_value;
   logic [3:0]  elem_count;
   logic        ready_input_matrix, error_overflow, error_incomplete;
   int          checks = 0;
   int          errors = 0;

   keypad_matrix_loader dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .key_valid          (key_valid),
      .key_code           (key_code),
      .X_out              (X_out),
      .y_out              (y_out),
      .entry_value        (entry_value),
      .elem_count         (elem_count),
      .ready_input_matrix (ready_input_matrix),
      .error_overflow     (error_overflow),
      .error_incomplete   (error_incomplete)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] c);
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = c;
      @(negedge clk);
      key_valid = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_x"}, 128'(X_out), 128'd0);
      check({tag, "_y"}, 128'(y_out), 128'd0);
      check({tag, "_entry"}, 128'(entry_value), 128'd0);
      check({tag, "_count"}, 128'(elem_count), 128'd0);
      check({tag, "_flags"}, 128'({ready_input_matrix, error_overflow, error_incomplete}), 128'd0);
   endtask

   initial begin
      key_valid = 1'b1;
      key_code  = 4'd5;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      key_code = 4'hE;
      @(negedge clk);
      check_all_zero("reset_enter");
      key_valid = 1'b0;
      rst_n     = 1'b1;

      press(4'd1);
      press(4'd2);
      check("entry_12", 128'(entry_value), 128'd12);
      press(4'hE);
      check("x0_12", 128'(X_out[11:0]), 128'd12);
      check("count_1", 128'(elem_count), 128'd1);
      check("entry_zeroed", 128'(entry_value), 128'd0);
      for (int k = 3; k <= 9; k++) begin
         press(4'(k));
         press(4'hE);
      end
      press(4'd1);
      press(4'd0);
      press(4'hE);
      check("x_full", 128'(X_out), 128'({12'd7, 12'd6, 12'd5, 12'd4, 12'd3, 12'd12}));
      check("y_full", 128'(y_out), 128'({12'd10, 12'd9, 12'd8}));
      check("count_9", 128'(elem_count), 128'd9);
      check("ready_before_done", 128'(ready_input_matrix), 128'd0);
      press(4'd5);
      check("digit_in_full", 128'(entry_value), 128'd0);
      press(4'hD);
      check("ready_after_done", 128'(ready_input_matrix), 128'd1);
      press(4'hE);
      check("enter_in_loaded", 128'(elem_count), 128'd9);
      check("y_kept_loaded", 128'(y_out), 128'({12'd10, 12'd9, 12'd8}));
      press(4'hC);
      check_all_zero("clear_loaded");

      press(4'd4);
      press(4'd0);
      press(4'd9);
      press(4'd5);
      check("entry_4095", 128'(entry_value), 128'd4095);
      check("no_ovf_yet", 128'(error_overflow), 128'd0);
      press(4'd7);
      check("entry_held", 128'(entry_value), 128'd4095);
      check("ovf_set", 128'(error_overflow), 128'd1);
      press(4'hE);
      check("x0_4095", 128'(X_out[11:0]), 128'd4095);

      press(4'd5);
      press(4'hC);
      check("clear_collect_entry", 128'(entry_value), 128'd0);
      press(4'hE);
      check("x1_zero", 128'(X_out[23:12]), 128'd0);
      check("count_2", 128'(elem_count), 128'd2);
      check("ovf_sticky", 128'(error_overflow), 128'd1);

      press(4'hE);
      press(4'hD);
      check("incomplete_set", 128'(error_incomplete), 128'd1);
      check("ready_early", 128'(ready_input_matrix), 128'd0);
      press(4'hE);
      check("count_4", 128'(elem_count), 128'd4);

      press(4'd7);
      press(4'hA);
      check("entry_7", 128'(entry_value), 128'd7);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_all_zero("reset_mid");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
